// File: rtl/cam_capture_rgb332.sv
// OV7670-style RGB565 capture: registers the camera bus, packs byte pairs to RGB332
// and streams them into the frame buffer, one frame per start request.
module cam_capture_rgb332 #(
  parameter int H_PIX   = 640,
  parameter int V_LINES = 480,
  parameter int ADDR_W  = 19
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              start_i,
  input  logic              vsync_i,
  input  logic              href_i,
  input  logic [7:0]        px_data_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] adr_o,
  output logic [7:0]        dat_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   pix_cnt_o
);
  localparam int              N_PIX   = H_PIX * V_LINES;
  localparam logic [ADDR_W:0] N_PIX_C = (ADDR_W+1)'(N_PIX);
  localparam logic [ADDR_W:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, ARM, SYNC, CAPTURE, DONE} state_t;
  state_t state, state_nxt;

  logic            vs_q, vs_qq, hr_q;
  logic [7:0]      d_q;
  logic            ph;
  logic [5:0]      a_q;
  logic            vs_rise, vs_fall, pix_ev;
  logic [ADDR_W:0] pix_nxt;

  assign vs_rise = vs_q & ~vs_qq;
  assign vs_fall = ~vs_q & vs_qq;
  assign pix_ev  = (state == CAPTURE) && hr_q && ph;
  // pixel count saturates instead of wrapping so oversize frames still flag err_o
  assign pix_nxt = (pix_ev && pix_cnt_o != CNT_MAX) ? pix_cnt_o + (ADDR_W+1)'(1) : pix_cnt_o;
  assign busy_o  = (state == ARM) || (state == SYNC) || (state == CAPTURE);
  assign done_o  = (state == DONE);

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      vs_q  <= 1'b0;
      vs_qq <= 1'b0;
      hr_q  <= 1'b0;
      d_q   <= '0;
    end else begin
      vs_q  <= vsync_i;
      vs_qq <= vs_q;
      hr_q  <= href_i;
      d_q   <= px_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = ARM;
      ARM:     if (vs_q)    state_nxt = SYNC;
      SYNC:    if (vs_fall) state_nxt = CAPTURE;
      CAPTURE: if (vs_rise) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      we_o      <= 1'b0;
      adr_o     <= '0;
      dat_o     <= '0;
      err_o     <= 1'b0;
      pix_cnt_o <= '0;
      ph        <= 1'b0;
      a_q       <= '0;
    end else begin
      we_o <= 1'b0;
      ph   <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          err_o     <= 1'b0;
          pix_cnt_o <= '0;
        end
        SYNC: if (vs_fall) adr_o <= '0;
        CAPTURE: begin
          if (hr_q) begin
            if (!ph) begin
              a_q <= {d_q[7:5], d_q[2:0]};
              ph  <= 1'b1;
            end else begin
              pix_cnt_o <= pix_nxt;
              // addresses past the last frame-buffer word are dropped, adr_o holds
              if (pix_cnt_o < N_PIX_C) begin
                we_o  <= 1'b1;
                adr_o <= pix_cnt_o[ADDR_W-1:0];
                dat_o <= {a_q, d_q[4:3]};
              end
            end
          end
          if (vs_rise) err_o <= (pix_nxt != N_PIX_C);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cam_capture_rgb332.sv
// Directed bench for cam_capture_rgb332 on a reduced 16x6 frame.
module tb_cam_capture_rgb332;
  localparam int H  = 16;
  localparam int V  = 6;
  localparam int AW = 7;
  localparam int N  = H * V;
  localparam logic [7:0] PX_STD = 8'b111_101_11; // A=E5, B=1F
  localparam logic [7:0] PX_ONE = 8'b101_100_10; // A=A4, B=10

  logic          clk_i = 1'b0;
  logic          rst = 1'b0;
  logic          start_i = 1'b0, vsync_i = 1'b0, href_i = 1'b0;
  logic [7:0]    px_data_i = '0;
  logic          we_o, busy_o, done_o, err_o;
  logic [AW-1:0] adr_o;
  logic [7:0]    dat_o;
  logic [AW:0]   pix_cnt_o;

  cam_capture_rgb332 #(.H_PIX(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .clk_i(clk_i), .rst(rst), .start_i(start_i), .vsync_i(vsync_i), .href_i(href_i),
    .px_data_i(px_data_i), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .pix_cnt_o(pix_cnt_o));

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  logic [AW-1:0] wr_adr[$];
  logic [7:0]    wr_dat[$];
  int            wr_cyc[$];
  int            done_cnt = 0;
  logic          err_at_done = 1'b0;
  logic [AW:0]   pix_at_done = '0;
  always @(negedge clk_i) begin
    if (we_o) begin
      wr_adr.push_back(adr_o);
      wr_dat.push_back(dat_o);
      wr_cyc.push_back(cyc);
    end
    if (done_o) begin
      done_cnt    <= done_cnt + 1;
      err_at_done <= err_o;
      pix_at_done <= pix_cnt_o;
    end
  end

  int n_chk = 0, n_fail = 0;
  int b0_cyc = 0;

  task automatic drive(input logic v, input logic h, input logic [7:0] d);
    @(negedge clk_i);
    vsync_i = v; href_i = h; px_data_i = d;
  endtask

  task automatic pulse_start();
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
  endtask

  // One camera frame: vsync gap, lines of 2*H bytes (+1 stray byte on odd_line),
  // then vsync rise. rst_at >= 0 pulls reset low right after that pixel's byte B.
  task automatic cam_frame(input int lines, input int odd_line, input logic [7:0] a0,
                           input logic [7:0] b0, input int rst_at);
    int p = 0;
    repeat (4) drive(1'b1, 1'b0, 8'h00);
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    for (int l = 0; l < lines; l++) begin
      for (int x = 0; x < H; x++) begin
        drive(1'b0, 1'b1, (l == 0 && x == 0) ? a0 : 8'hE5);
        drive(1'b0, 1'b1, (l == 0 && x == 0) ? b0 : 8'h1F);
        if (l == 0 && x == 0) b0_cyc = cyc;
        if (p == rst_at) begin
          #2 rst = 1'b0;
          href_i = 1'b0;
          return;
        end
        p++;
      end
      if (l == odd_line) drive(1'b0, 1'b1, 8'h00);
      repeat (3) drive(1'b0, 1'b0, 8'h00);
    end
    repeat (6) drive(1'b1, 1'b0, 8'h00);
  endtask

  task automatic wait_done(input int base);
    int k = 0;
    while (done_cnt == base && k < 100) begin
      @(negedge clk_i);
      k++;
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    n_chk++; if (we_o !== 1'b0)    begin n_fail++; $display("FAIL reset_we got %0b want 0", we_o); end
    n_chk++; if (adr_o !== '0)     begin n_fail++; $display("FAIL reset_adr got %0d want 0", adr_o); end
    n_chk++; if (dat_o !== 8'h00)  begin n_fail++; $display("FAIL reset_dat got %h want 00", dat_o); end
    n_chk++; if (busy_o !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy_o); end
    n_chk++; if (done_o !== 1'b0)  begin n_fail++; $display("FAIL reset_done got %0b want 0", done_o); end
    n_chk++; if (err_o !== 1'b0)   begin n_fail++; $display("FAIL reset_err got %0b want 0", err_o); end
    n_chk++; if (pix_cnt_o !== '0) begin n_fail++; $display("FAIL reset_pix got %0d want 0", pix_cnt_o); end
    rst = 1'b1;
    drive(1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_full_frame();
    int wb = wr_adr.size(), db = done_cnt, bad_a = 0, bad_d = 0;
    pulse_start();
    #1;
    n_chk++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL full_busy got %0b want 1", busy_o); end
    cam_frame(V, -1, 8'hE5, 8'h1F, -1);
    wait_done(db);
    for (int i = wb; i < wr_adr.size(); i++) begin
      if (wr_adr[i] !== AW'(i - wb)) bad_a++;
      if (wr_dat[i] !== PX_STD) bad_d++;
    end
    n_chk++; if (wr_adr.size() - wb !== N) begin n_fail++; $display("FAIL full_writes got %0d want %0d", wr_adr.size() - wb, N); end
    n_chk++; if (bad_a !== 0) begin n_fail++; $display("FAIL full_adr_seq got %0d bad want 0", bad_a); end
    n_chk++; if (bad_d !== 0) begin n_fail++; $display("FAIL full_dat got %0d bad want 0", bad_d); end
    n_chk++; if (done_cnt - db !== 1) begin n_fail++; $display("FAIL full_done got %0d want 1", done_cnt - db); end
    n_chk++; if (err_at_done !== 1'b0) begin n_fail++; $display("FAIL full_err got %0b want 0", err_at_done); end
    n_chk++; if (pix_at_done !== (AW+1)'(N)) begin n_fail++; $display("FAIL full_pix got %0d want %0d", pix_at_done, N); end
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL full_idle_busy got %0b want 0", busy_o); end
  endtask

  task automatic test_single_pixel();
    int wb = wr_adr.size(), db = done_cnt;
    pulse_start();
    cam_frame(V, -1, 8'hA4, 8'h10, -1);
    wait_done(db);
    n_chk++; if (wr_adr.size() <= wb) begin n_fail++; $display("FAIL px_any got %0d writes want >0", wr_adr.size() - wb); end
    else begin
      n_chk++; if (wr_dat[wb] !== PX_ONE) begin n_fail++; $display("FAIL px_dat got %h want %h", wr_dat[wb], PX_ONE); end
      n_chk++; if (wr_adr[wb] !== '0) begin n_fail++; $display("FAIL px_adr got %0d want 0", wr_adr[wb]); end
      n_chk++; if (wr_cyc[wb] !== b0_cyc + 2) begin n_fail++; $display("FAIL px_latency got %0d want %0d", wr_cyc[wb], b0_cyc + 2); end
      n_chk++; if (wr_dat[wb+1] !== PX_STD) begin n_fail++; $display("FAIL px_next got %h want %h", wr_dat[wb+1], PX_STD); end
    end
  endtask

  task automatic test_mid_frame_start();
    int wb, db = done_cnt, bad_d = 0;
    drive(1'b0, 1'b0, 8'h00);
    pulse_start();
    wb = wr_adr.size();
    for (int i = 0; i < 4 * H; i++) drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    n_chk++; if (wr_adr.size() !== wb) begin n_fail++; $display("FAIL mid_nowrite got %0d want 0", wr_adr.size() - wb); end
    cam_frame(V, -1, 8'hE5, 8'h1F, -1);
    wait_done(db);
    for (int i = wb; i < wr_adr.size(); i++) if (wr_dat[i] !== PX_STD) bad_d++;
    n_chk++; if (wr_adr.size() - wb !== N) begin n_fail++; $display("FAIL mid_writes got %0d want %0d", wr_adr.size() - wb, N); end
    n_chk++; if (wr_adr[wb] !== '0) begin n_fail++; $display("FAIL mid_first_adr got %0d want 0", wr_adr[wb]); end
    n_chk++; if (bad_d !== 0) begin n_fail++; $display("FAIL mid_dat got %0d bad want 0", bad_d); end
    n_chk++; if (err_at_done !== 1'b0) begin n_fail++; $display("FAIL mid_err got %0b want 0", err_at_done); end
  endtask

  task automatic test_short_frame();
    int wb = wr_adr.size(), db = done_cnt;
    pulse_start();
    cam_frame(V - 1, -1, 8'hE5, 8'h1F, -1);
    wait_done(db);
    n_chk++; if (wr_adr.size() - wb !== N - H) begin n_fail++; $display("FAIL short_writes got %0d want %0d", wr_adr.size() - wb, N - H); end
    n_chk++; if (done_cnt - db !== 1) begin n_fail++; $display("FAIL short_done got %0d want 1", done_cnt - db); end
    n_chk++; if (err_at_done !== 1'b1) begin n_fail++; $display("FAIL short_err got %0b want 1", err_at_done); end
    n_chk++; if (pix_at_done !== (AW+1)'(N - H)) begin n_fail++; $display("FAIL short_pix got %0d want %0d", pix_at_done, N - H); end
    n_chk++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL short_err_sticky got %0b want 1", err_o); end
  endtask

  task automatic test_long_frame();
    int wb = wr_adr.size(), db = done_cnt;
    pulse_start();
    #1;
    n_chk++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL long_err_clear got %0b want 0", err_o); end
    cam_frame(V + 1, -1, 8'hE5, 8'h1F, -1);
    wait_done(db);
    n_chk++; if (wr_adr.size() - wb !== N) begin n_fail++; $display("FAIL long_writes got %0d want %0d", wr_adr.size() - wb, N); end
    n_chk++; if (wr_adr[wr_adr.size()-1] !== AW'(N - 1)) begin n_fail++; $display("FAIL long_last_adr got %0d want %0d", wr_adr[wr_adr.size()-1], N - 1); end
    n_chk++; if (adr_o !== AW'(N - 1)) begin n_fail++; $display("FAIL long_adr_hold got %0d want %0d", adr_o, N - 1); end
    n_chk++; if (err_at_done !== 1'b1) begin n_fail++; $display("FAIL long_err got %0b want 1", err_at_done); end
    n_chk++; if (pix_at_done !== (AW+1)'(N + H)) begin n_fail++; $display("FAIL long_pix got %0d want %0d", pix_at_done, N + H); end
  endtask

  task automatic test_odd_line();
    int wb = wr_adr.size(), db = done_cnt, bad_d = 0, bad_a = 0;
    pulse_start();
    cam_frame(V, 2, 8'hE5, 8'h1F, -1);
    wait_done(db);
    for (int i = wb; i < wr_adr.size(); i++) begin
      if (wr_dat[i] !== PX_STD) bad_d++;
      if (wr_adr[i] !== AW'(i - wb)) bad_a++;
    end
    n_chk++; if (wr_adr.size() - wb !== N) begin n_fail++; $display("FAIL odd_writes got %0d want %0d", wr_adr.size() - wb, N); end
    n_chk++; if (bad_d !== 0) begin n_fail++; $display("FAIL odd_dat got %0d bad want 0", bad_d); end
    n_chk++; if (bad_a !== 0) begin n_fail++; $display("FAIL odd_adr got %0d bad want 0", bad_a); end
    n_chk++; if (err_at_done !== 1'b0) begin n_fail++; $display("FAIL odd_err got %0b want 0", err_at_done); end
  endtask

  task automatic test_reset_mid();
    int nw, wb, db, bad_a = 0;
    pulse_start();
    cam_frame(V, -1, 8'hE5, 8'h1F, 10);
    #1;
    n_chk++; if (we_o !== 1'b0)    begin n_fail++; $display("FAIL rmid_we got %0b want 0", we_o); end
    n_chk++; if (busy_o !== 1'b0)  begin n_fail++; $display("FAIL rmid_busy got %0b want 0", busy_o); end
    n_chk++; if (adr_o !== '0)     begin n_fail++; $display("FAIL rmid_adr got %0d want 0", adr_o); end
    n_chk++; if (pix_cnt_o !== '0) begin n_fail++; $display("FAIL rmid_pix got %0d want 0", pix_cnt_o); end
    nw = wr_adr.size();
    repeat (2) drive(1'b0, 1'b0, 8'h00);
    rst = 1'b1;
    for (int i = 0; i < 2 * H; i++) drive(1'b0, (i % 4) != 3, 8'hE5);
    drive(1'b0, 1'b0, 8'h00);
    n_chk++; if (wr_adr.size() !== nw) begin n_fail++; $display("FAIL rmid_nowrite got %0d want 0", wr_adr.size() - nw); end
    wb = wr_adr.size(); db = done_cnt;
    pulse_start();
    cam_frame(V, -1, 8'hE5, 8'h1F, -1);
    wait_done(db);
    for (int i = wb; i < wr_adr.size(); i++) if (wr_adr[i] !== AW'(i - wb)) bad_a++;
    n_chk++; if (wr_adr.size() - wb !== N) begin n_fail++; $display("FAIL rmid_writes got %0d want %0d", wr_adr.size() - wb, N); end
    n_chk++; if (bad_a !== 0) begin n_fail++; $display("FAIL rmid_adr_seq got %0d bad want 0", bad_a); end
    n_chk++; if (err_at_done !== 1'b0) begin n_fail++; $display("FAIL rmid_err got %0b want 0", err_at_done); end
  endtask

  task automatic test_start_ignored_busy();
    int wb = wr_adr.size(), db = done_cnt;
    pulse_start();
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    pulse_start();
    cam_frame(V, -1, 8'hE5, 8'h1F, -1);
    wait_done(db);
    repeat (20) @(negedge clk_i);
    n_chk++; if (done_cnt - db !== 1) begin n_fail++; $display("FAIL busy_start_done got %0d want 1", done_cnt - db); end
    n_chk++; if (wr_adr.size() - wb !== N) begin n_fail++; $display("FAIL busy_start_writes got %0d want %0d", wr_adr.size() - wb, N); end
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL busy_start_idle got %0b want 0", busy_o); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_single_pixel();
    test_mid_frame_start();
    test_short_frame();
    test_long_frame();
    test_odd_line();
    test_reset_mid();
    test_start_ignored_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
